onehot_state_sequencer: RTL

//   Generates the 4-bit one-hot 'state' sequence 1000->0100->0010->0001->1000 that the
//   one-hot-to-binary encoder blocks (M3/M4 family) consume. It is the transmitting end
//   of that state bus and replaces hand-written stimulus with a synthesizable sequencer.
//   A programmable dwell counter sets how long each state holds. A load port forces any

---
 rtl/onehot_state_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/onehot_state_sequencer.sv
// One-hot state sequencer: rotates a single hot bit MSB->LSB with a programmable
// per-state dwell, and can be forced to any state by binary index.
module onehot_state_sequencer #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          ck,
   input  logic          r,
   input  logic          en,
   input  logic [DW-1:0] dwell,
   input  logic          load,
   input  logic [IW-1:0] load_idx,
   output logic [N-1:0]  state,
   output logic [IW-1:0] idx,
   output logic          step,
   output logic          wrap,
   output logic          err
);

   // Reset state: index 0 is the MSB of the one-hot bus
   localparam logic [N-1:0] ST_RESET = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0]  r_state;
   logic [IW-1:0] r_idx;
   logic [DW-1:0] r_cnt;
   logic          r_step;
   logic          r_wrap;
   logic          r_err;

   logic [N-1:0]  w_state_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic [DW-1:0] w_cnt_nxt;
   logic          w_step_nxt;
   logic          w_wrap_nxt;
   logic          w_err_nxt;
   logic          w_load_ok;
   logic          w_last;
   logic [N-1:0]  w_load_oh;

   assign w_load_ok = (32'(load_idx) < N);
   assign w_last    = (r_idx == IW'(N-1));
   assign w_load_oh = ST_RESET >> load_idx;

   // Next-state: load beats advance; rejected loads only raise err
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_step_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (load) begin
         if (w_load_ok) begin
            w_state_nxt = w_load_oh;
            w_idx_nxt   = load_idx;
            w_cnt_nxt   = '0;
         end else begin
            w_err_nxt = 1'b1;
         end
      end else if (en) begin
         // >= so that shrinking dwell below the running count advances promptly
         if (r_cnt >= dwell) begin
            w_state_nxt = {r_state[0], r_state[N-1:1]};
            w_idx_nxt   = w_last ? '0 : r_idx + IW'(1);
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
            w_wrap_nxt  = w_last;
         end else begin
            w_cnt_nxt = r_cnt + DW'(1);
         end
      end
   end

   // State register, synchronous reset
   always_ff @(posedge ck) begin
      if (r) begin
         r_state <= ST_RESET;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_step  <= w_step_nxt;
         r_wrap  <= w_wrap_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign state = r_state;
   assign idx   = r_idx;
   assign step  = r_step;
   assign wrap  = r_wrap;
   assign err   = r_err;

endmodule
